// File: rtl/input_scanner.sv
// Debounced multi-channel input scanner.
// Each raw field input is synchronised, then accepted as a new stable level
// only after it has differed from the current level for DEBOUNCE consecutive
// cycles. Accepted changes raise a per-channel sticky flag that the reader
// clears with read_ack; any_change summarises all flags.
module input_scanner #(
    parameter int WIDTH    = 3,
    parameter int SIZE     = 2**WIDTH,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SIZE-1:0]  raw_in,
    input  logic [WIDTH-1:0] address,
    input  logic             chip_enable,
    input  logic             read_ack,
    output logic             output_data,
    output logic             change_data,
    output logic             any_change
);

    // Counter just wide enough to hold DEBOUNCE; it is reloaded before it
    // can pass DEBOUNCE-1, so it never wraps.
    localparam int              CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

    logic [SIZE-1:0] sync1_q;
    logic [SIZE-1:0] sync2_q;
    logic [SIZE-1:0] stable_q;
    logic [SIZE-1:0] stable_d;
    logic [SIZE-1:0] change_q;
    logic [SIZE-1:0] change_d;
    logic [CW-1:0]   cnt_q [SIZE];
    logic [CW-1:0]   cnt_d [SIZE];
    logic [SIZE-1:0] set_chg;
    logic [SIZE-1:0] ack_sel;

    // Decode which channel a qualified read_ack clears this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ack_sel = '0;
        for (int i = 0; i < SIZE; i++) begin
            ack_sel[i] = read_ack && chip_enable && (int'(address) == i);
        end
    end

    // Per-channel debounce: count cycles of disagreement, accept on the last.
    always_comb begin
        stable_d = stable_q;
        set_chg  = '0;
        for (int i = 0; i < SIZE; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    set_chg[i]  = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // A newly accepted change wins over a same-cycle acknowledge.
        change_d = set_chg | (change_q & ~ack_sel);
    end

    // Synchroniser, stable levels, counters and change flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            change_q <= '0;
            // NOTE: the counter array is ordinary flops, not a RAM, so it
            // takes the asynchronous reset along with the rest of the state.
            for (int i = 0; i < SIZE; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values; this is what makes sync1 -> sync2 two stages.
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            change_q <= change_d;
            for (int i = 0; i < SIZE; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Read mux for the addressed channel; an out-of-range address reads 0.
    always_comb begin
        output_data = 1'b0;
        change_data = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (int'(address) == i) begin
                output_data = chip_enable & stable_q[i];
                change_data = chip_enable & change_q[i];
            end
        end
        any_change = |change_q;
    end

endmodule
